pwm_deadtime_gen: RTL and testbench

//  Downstream stage of the 64-bit pipelined PWM generator. Consumes its single-ended
//  pwm_out and drives a complementary high-side/low-side gate pair. A programmable

---
 rtl/pwm_deadtime_gen.sv | 220 ++++++++++++++++++++++
 tb/tb_pwm_deadtime_gen.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_deadtime_gen.sv
// -----------------------------------------------------------------------------
// pwm_deadtime_gen
//
// Purpose:
//   Turns the single-ended PWM request from the pipelined PWM counter into a
//   complementary high-side / low-side gate pair for the power-stage pad
//   drivers. Every hand-over between the two sides passes through a
//   programmable dead time. During the dead time both gates are inactive, so
//   the two active levels can never overlap.
//
// Parameters:
//   DT_WIDTH  width of dead_time (cycles)
//   HI_POL    active level of out_hi (1 = active-high)
//   LO_POL    active level of out_lo (1 = active-high)
//
// Ports:
//   clk            in   rising-edge clock
//   rst_n          in   synchronous active-low reset
//   en             in   block enable; 0 forces OFF with both gates inactive
//   pwm_in         in   1 = request high side, 0 = request low side
//   dead_time      in   dead-time length in cycles (0 behaves as 1); sampled
//                       only when a dead-time state is entered
//   out_hi         out  high-side gate (registered)
//   out_lo         out  low-side gate (registered)
//   dt_active      out  1 while a dead time is running (registered)
//   fault          in   (DEADTIME_FAULT_EN) synchronous fault request
//   fault_clr      in   (DEADTIME_FAULT_EN) fault clear
//   fault_latched  out  (DEADTIME_FAULT_EN) registered fault flag
//
// Build option:
//   DEADTIME_FAULT_EN  adds the fault ports and a latched FAULT state that
//                      overrides en and holds both gates inactive until an
//                      explicit clear with fault deasserted.
// -----------------------------------------------------------------------------
module pwm_deadtime_gen #(
    parameter int DT_WIDTH = 16,
    parameter bit HI_POL   = 1'b1,
    parameter bit LO_POL   = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                pwm_in,
    input  logic [DT_WIDTH-1:0] dead_time,
`ifdef DEADTIME_FAULT_EN
    input  logic                fault,
    input  logic                fault_clr,
    output logic                fault_latched,
`endif
    output logic                out_hi,
    output logic                out_lo,
    output logic                dt_active
);

    // State encoding
    localparam logic [2:0] ST_OFF      = 3'd0;
    localparam logic [2:0] ST_DT_TO_HI = 3'd1;
    localparam logic [2:0] ST_HI       = 3'd2;
    localparam logic [2:0] ST_DT_TO_LO = 3'd3;
    localparam logic [2:0] ST_LO       = 3'd4;
`ifdef DEADTIME_FAULT_EN
    localparam logic [2:0] ST_FAULT    = 3'd5;
`endif

    // Gate levels for each polarity setting
    localparam logic HI_ON  = HI_POL;
    localparam logic HI_OFF = ~HI_POL;
    localparam logic LO_ON  = LO_POL;
    localparam logic LO_OFF = ~LO_POL;

    localparam logic [DT_WIDTH-1:0] DT_ONE = {{(DT_WIDTH-1){1'b0}}, 1'b1};

    logic [2:0]          state;
    logic [DT_WIDTH-1:0] cnt;
    logic [DT_WIDTH-1:0] cnt_load;

    // Reload value for the dead-time counter: Neff-1, where a programmed
    // zero still yields one both-inactive cycle. The counter then reaches
    // zero Neff-1 edges after entry and the new side turns on one edge later,
    // which gives exactly Neff inactive cycles.
    always_comb begin
        cnt_load = '0;
        if (dead_time != '0)
            cnt_load = dead_time - DT_ONE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_OFF;
            cnt       <= '0;
            out_hi    <= HI_OFF;
            out_lo    <= LO_OFF;
            dt_active <= 1'b0;
`ifdef DEADTIME_FAULT_EN
            fault_latched <= 1'b0;
`endif
        end
`ifdef DEADTIME_FAULT_EN
        else if (fault) begin
            // Fault wins over en and over any hand-over in progress.
            state         <= ST_FAULT;
            cnt           <= '0;
            out_hi        <= HI_OFF;
            out_lo        <= LO_OFF;
            dt_active     <= 1'b0;
            fault_latched <= 1'b1;
        end
        else if (state == ST_FAULT) begin
            // fault is known low here; only an explicit clear leaves FAULT,
            // en has no say while latched.
            out_hi    <= HI_OFF;
            out_lo    <= LO_OFF;
            dt_active <= 1'b0;
            if (fault_clr) begin
                state         <= ST_OFF;
                fault_latched <= 1'b0;
            end
        end
`endif
        else if (!en) begin
            state     <= ST_OFF;
            cnt       <= '0;
            out_hi    <= HI_OFF;
            out_lo    <= LO_OFF;
            dt_active <= 1'b0;
        end
        else begin
            case (state)
                ST_OFF: begin
                    // Leaving OFF always goes through a full dead time.
                    state     <= pwm_in ? ST_DT_TO_HI : ST_DT_TO_LO;
                    cnt       <= cnt_load;
                    out_hi    <= HI_OFF;
                    out_lo    <= LO_OFF;
                    dt_active <= 1'b1;
                end

                ST_HI: begin
                    out_lo <= LO_OFF;
                    if (!pwm_in) begin
                        state     <= ST_DT_TO_LO;
                        cnt       <= cnt_load;
                        out_hi    <= HI_OFF;
                        dt_active <= 1'b1;
                    end
                    else begin
                        out_hi    <= HI_ON;
                        dt_active <= 1'b0;
                    end
                end

                ST_LO: begin
                    out_hi <= HI_OFF;
                    if (pwm_in) begin
                        state     <= ST_DT_TO_HI;
                        cnt       <= cnt_load;
                        out_lo    <= LO_OFF;
                        dt_active <= 1'b1;
                    end
                    else begin
                        out_lo    <= LO_ON;
                        dt_active <= 1'b0;
                    end
                end

                ST_DT_TO_HI: begin
                    out_lo <= LO_OFF;
                    if (!pwm_in) begin
                        // Request flipped back: restart the full count toward
                        // the low side, so short pulses are swallowed.
                        state     <= ST_DT_TO_LO;
                        cnt       <= cnt_load;
                        out_hi    <= HI_OFF;
                        dt_active <= 1'b1;
                    end
                    else if (cnt == '0) begin
                        state     <= ST_HI;
                        out_hi    <= HI_ON;
                        dt_active <= 1'b0;
                    end
                    else begin
                        cnt       <= cnt - DT_ONE;
                        out_hi    <= HI_OFF;
                        dt_active <= 1'b1;
                    end
                end

                ST_DT_TO_LO: begin
                    out_hi <= HI_OFF;
                    if (pwm_in) begin
                        state     <= ST_DT_TO_HI;
                        cnt       <= cnt_load;
                        out_lo    <= LO_OFF;
                        dt_active <= 1'b1;
                    end
                    else if (cnt == '0) begin
                        state     <= ST_LO;
                        out_lo    <= LO_ON;
                        dt_active <= 1'b0;
                    end
                    else begin
                        cnt       <= cnt - DT_ONE;
                        out_lo    <= LO_OFF;
                        dt_active <= 1'b1;
                    end
                end

                default: begin
                    // Unreachable encodings recover to the safe state.
                    state     <= ST_OFF;
                    cnt       <= '0;
                    out_hi    <= HI_OFF;
                    out_lo    <= LO_OFF;
                    dt_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// -----------------------------------------------------------------------------
// tb_pwm_deadtime_gen
//
// Directed segments: each segment holds the inputs steady for n cycles and
// states the gate activity expected right after each of those edges. The
// driver pushes one expectation per edge into a queue; an independent monitor
// pops one entry after every rising edge and compares. The low side is built
// active-low to exercise the polarity handling.
// -----------------------------------------------------------------------------
module tb_pwm_deadtime_gen;

    localparam int DTW = 16;
    localparam bit HP  = 1'b1;
    localparam bit LP  = 1'b0;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           en = 1'b0;
    logic           pwm_in = 1'b0;
    logic [DTW-1:0] dead_time = '0;
    logic           out_hi, out_lo, dt_active;
`ifdef DEADTIME_FAULT_EN
    logic           fault = 1'b0;
    logic           fault_clr = 1'b0;
    logic           fault_latched;
`endif

    typedef struct {
        logic ah;   // high side expected active
        logic al;   // low side expected active
        logic da;   // dt_active
        logic fl;   // fault_latched
        int   tid;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   done   = 1'b0;

    pwm_deadtime_gen #(
        .DT_WIDTH (DTW),
        .HI_POL   (HP),
        .LO_POL   (LP)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .pwm_in        (pwm_in),
        .dead_time     (dead_time),
`ifdef DEADTIME_FAULT_EN
        .fault         (fault),
        .fault_clr     (fault_clr),
        .fault_latched (fault_latched),
`endif
        .out_hi        (out_hi),
        .out_lo        (out_lo),
        .dt_active     (dt_active)
    );

    always #5 clk = ~clk;

    // Drive n cycles of fixed inputs; expected values describe the outputs
    // after each of those edges.
    task automatic seg(input int n, input logic r, input logic e, input logic p,
                       input int dt, input logic f, input logic fc,
                       input logic ah, input logic al, input logic da,
                       input logic fl, input int tid);
        exp_t x;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst_n     = r;
            en        = e;
            pwm_in    = p;
            dead_time = DTW'(dt);
`ifdef DEADTIME_FAULT_EN
            fault     = f;
            fault_clr = fc;
`else
            if (f || fc) $display("note: fault stimulus skipped in this build");
`endif
            x.ah = ah; x.al = al; x.da = da; x.fl = fl; x.tid = tid;
            exp_q.push_back(x);
        end
    endtask

    // Monitor: one expectation per rising edge, sampled 1 time unit later.
    initial begin
        exp_t x;
        logic eh, el;
        while (!done) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_hi == HP && out_lo == LP) begin
                errors++;
                $display("FAIL overlap t=%0t out_hi=%b out_lo=%b both active", $time, out_hi, out_lo);
            end
            if (exp_q.size() > 0) begin
                x  = exp_q.pop_front();
                eh = x.ah ? HP : ~HP;
                el = x.al ? LP : ~LP;
                checks++;
                if (out_hi !== eh || out_lo !== el || dt_active !== x.da) begin
                    errors++;
                    $display("FAIL test%0d t=%0t got hi=%b lo=%b dt=%b expected hi=%b lo=%b dt=%b",
                             x.tid, $time, out_hi, out_lo, dt_active, eh, el, x.da);
                end
`ifdef DEADTIME_FAULT_EN
                checks++;
                if (fault_latched !== x.fl) begin
                    errors++;
                    $display("FAIL test%0d_fault_latched t=%0t got %b expected %b",
                             x.tid, $time, fault_latched, x.fl);
                end
`endif
            end
        end
    end

    initial begin
        // seg(n, rst_n, en, pwm, dt, fault, clr, hi, lo, dt_active, latched, test)
        // Reset state
        seg(2, 0, 0, 0, 4, 0, 0,  0, 0, 0, 0, 0);

        // 1: dead_time=4, low side first, then hand over to high side
        seg(4,  1, 1, 0, 4, 0, 0,  0, 0, 1, 0, 1);
        seg(16, 1, 1, 0, 4, 0, 0,  0, 1, 0, 0, 1);
        seg(4,  1, 1, 1, 4, 0, 0,  0, 0, 1, 0, 1);
        seg(4,  1, 1, 1, 4, 0, 0,  1, 0, 0, 0, 1);

        // 2: dead_time=0 acts as 1, toggling every 5 cycles
        for (int k = 0; k < 2; k++) begin
            seg(1, 1, 1, 0, 0, 0, 0,  0, 0, 1, 0, 2);
            seg(4, 1, 1, 0, 0, 0, 0,  0, 1, 0, 0, 2);
            seg(1, 1, 1, 1, 0, 0, 0,  0, 0, 1, 0, 2);
            seg(4, 1, 1, 1, 0, 0, 0,  1, 0, 0, 0, 2);
        end

        // 3: dead_time=8, 3-cycle high pulse during LO is swallowed
        seg(8, 1, 1, 0, 8, 0, 0,  0, 0, 1, 0, 3);
        seg(4, 1, 1, 0, 8, 0, 0,  0, 1, 0, 0, 3);
        seg(3, 1, 1, 1, 8, 0, 0,  0, 0, 1, 0, 3);
        seg(8, 1, 1, 0, 8, 0, 0,  0, 0, 1, 0, 3);
        seg(3, 1, 1, 0, 8, 0, 0,  0, 1, 0, 0, 3);

        // 4: dead_time 6 -> 2 mid dead time; current lasts 6, next lasts 2
        seg(3, 1, 1, 1, 6, 0, 0,  0, 0, 1, 0, 4);
        seg(3, 1, 1, 1, 2, 0, 0,  0, 0, 1, 0, 4);
        seg(3, 1, 1, 1, 2, 0, 0,  1, 0, 0, 0, 4);
        seg(2, 1, 1, 0, 2, 0, 0,  0, 0, 1, 0, 4);
        seg(3, 1, 1, 0, 2, 0, 0,  0, 1, 0, 0, 4);

        // 5: reset while HI, then en=0 while LO; each recovers via full DT
        seg(2, 1, 1, 1, 2, 0, 0,  0, 0, 1, 0, 5);
        seg(3, 1, 1, 1, 2, 0, 0,  1, 0, 0, 0, 5);
        seg(1, 0, 1, 1, 2, 0, 0,  0, 0, 0, 0, 5);
        seg(2, 1, 1, 1, 2, 0, 0,  0, 0, 1, 0, 5);
        seg(3, 1, 1, 1, 2, 0, 0,  1, 0, 0, 0, 5);
        seg(2, 1, 1, 0, 2, 0, 0,  0, 0, 1, 0, 5);
        seg(3, 1, 1, 0, 2, 0, 0,  0, 1, 0, 0, 5);
        seg(1, 1, 0, 0, 2, 0, 0,  0, 0, 0, 0, 5);
        seg(2, 1, 1, 0, 2, 0, 0,  0, 0, 1, 0, 5);
        seg(2, 1, 1, 0, 2, 0, 0,  0, 1, 0, 0, 5);

        // 7: dead_time=1 gives the same single dead cycle as 0
        seg(1, 1, 1, 1, 1, 0, 0,  0, 0, 1, 0, 7);
        seg(2, 1, 1, 1, 1, 0, 0,  1, 0, 0, 0, 7);

`ifdef DEADTIME_FAULT_EN
        // 6: fault in HI, clear ignored while fault high, clean clear -> OFF
        seg(1, 1, 1, 1, 2, 1, 0,  0, 0, 0, 1, 6);
        seg(2, 1, 1, 1, 2, 0, 0,  0, 0, 0, 1, 6);
        seg(1, 1, 0, 1, 2, 0, 0,  0, 0, 0, 1, 6);
        seg(1, 1, 1, 1, 2, 1, 1,  0, 0, 0, 1, 6);
        seg(1, 1, 1, 1, 2, 0, 1,  0, 0, 0, 0, 6);
        seg(2, 1, 1, 1, 2, 0, 0,  0, 0, 1, 0, 6);
        seg(2, 1, 1, 1, 2, 0, 0,  1, 0, 0, 0, 6);
`endif

        // Let the monitor drain the queue, bounded.
        for (int w = 0; w < 20 && exp_q.size() > 0; w++) @(posedge clk);
        @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
